// File: rtl/mips_decode_stage.sv
// mips_decode_stage: MIPS decode stage with a valid/ready handshake on both sides.
// Optional write-back forwarding into A/B is enabled by defining MIPS_DECODE_FWD_EN.
module mips_decode_stage (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] Instr_In,
   input  logic        Instr_Valid,
   output logic        Instr_Ready,
   output logic [4:0]  SR1,
   output logic [4:0]  SR2,
   input  logic [31:0] ReadReg1,
   input  logic [31:0] ReadReg2,
   input  logic        WB_RegW,
   input  logic [4:0]  WB_DR,
   input  logic [31:0] WB_Data,
   output logic        Op_Valid,
   input  logic        Op_Ready,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [31:0] Imm,
   output logic [2:0]  ALUOp,
   output logic [4:0]  DR_Out,
   output logic        RegW_Out,
   output logic        ALUSrc,
   output logic        MemR,
   output logic        MemW,
   output logic        Branch,
   output logic        Illegal
);
   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
   state_t state, next_state;
   logic accept, capture;
   logic [31:0] instr, word, op_a, op_b, imm_d;
   logic [5:0] opc, fn;
   logic is_r, addi, andi, ori, lw, sw, beq, legal, regw_d;
   logic [2:0] alu_d;
   logic [4:0] dr_d;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= next_state;
   always_comb
      next_state = state == IDLE ? (Instr_Valid ? READ : IDLE) :
                   state == READ ? HOLD : (Op_Ready ? IDLE : HOLD);
   always_comb begin
      Instr_Ready = state == IDLE;
      Op_Valid = state == HOLD;
      accept = state == IDLE && Instr_Valid;
      capture = state == READ;
   end
   // register addresses come straight from the bus until an instruction is latched
   assign word = state == IDLE ? Instr_In : instr;
   assign SR1 = word[25:21];
   assign SR2 = word[20:16];
   always_comb begin
      opc = instr[31:26];
      fn = instr[5:0];
      is_r = opc == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
      addi = opc == 6'h08;
      andi = opc == 6'h0C;
      ori = opc == 6'h0D;
      lw = opc == 6'h23;
      sw = opc == 6'h2B;
      beq = opc == 6'h04;
      legal = is_r || addi || andi || ori || lw || sw || beq;
      dr_d = opc == 6'h00 ? instr[15:11] : instr[20:16];
      regw_d = (is_r || addi || andi || ori || lw) && dr_d != 5'd0;
      imm_d = (andi || ori) ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
      alu_d = is_r ? (fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : fn == 6'h25 ? 3'd3 : fn == 6'h2A ? 3'd4 : 3'd0) :
              andi ? 3'd2 : ori ? 3'd3 : beq ? 3'd1 : 3'd0;
   end
`ifdef MIPS_DECODE_FWD_EN
   logic hit1, hit2, fwd1, fwd2;
   logic [31:0] fdat1, fdat2;
   assign hit1 = WB_RegW && WB_DR == SR1 && WB_DR != 5'd0;
   assign hit2 = WB_RegW && WB_DR == SR2 && WB_DR != 5'd0;
   // a write seen on the accept edge is remembered; one on the capture edge overrides it
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         fwd1 <= 1'b0;
         fwd2 <= 1'b0;
         fdat1 <= '0;
         fdat2 <= '0;
      end else if (accept) begin
         fwd1 <= hit1;
         fwd2 <= hit2;
         fdat1 <= WB_Data;
         fdat2 <= WB_Data;
      end
   assign op_a = hit1 ? WB_Data : fwd1 ? fdat1 : ReadReg1;
   assign op_b = hit2 ? WB_Data : fwd2 ? fdat2 : ReadReg2;
`else
   logic unused_wb;
   assign unused_wb = ^{WB_RegW, WB_DR, WB_Data};
   assign op_a = ReadReg1;
   assign op_b = ReadReg2;
`endif
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         instr <= '0;
         A <= '0;
         B <= '0;
         Imm <= '0;
         ALUOp <= '0;
         DR_Out <= '0;
         RegW_Out <= 1'b0;
         ALUSrc <= 1'b0;
         MemR <= 1'b0;
         MemW <= 1'b0;
         Branch <= 1'b0;
         Illegal <= 1'b0;
      end else begin
         if (accept) instr <= Instr_In;
         if (capture) begin
            A <= op_a;
            B <= op_b;
            Imm <= imm_d;
            ALUOp <= alu_d;
            DR_Out <= dr_d;
            RegW_Out <= regw_d;
            ALUSrc <= addi || andi || ori || lw || sw;
            MemR <= lw;
            MemW <= sw;
            Branch <= beq;
            Illegal <= !legal;
         end
      end
endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage: directed vector bench for mips_decode_stage with a register-file stub.
// Expectations follow MIPS_DECODE_FWD_EN when the macro is defined.
module tb_mips_decode_stage;
   logic CLK = 0, RST_N = 0;
   logic [31:0] Instr_In = 0, ReadReg1 = 0, ReadReg2 = 0, WB_Data = 0;
   logic Instr_Valid = 0, Op_Ready = 0, WB_RegW = 0;
   logic [4:0] WB_DR = 0, SR1, SR2, DR_Out;
   logic Instr_Ready, Op_Valid, RegW_Out, ALUSrc, MemR, MemW, Branch, Illegal;
   logic [31:0] A, B, Imm;
   logic [2:0] ALUOp;
   logic [109:0] ov;
   logic [31:0] rf [32];
   int n = 0, errs = 0;

   mips_decode_stage dut (
      .CLK(CLK), .RST_N(RST_N), .Instr_In(Instr_In), .Instr_Valid(Instr_Valid),
      .Instr_Ready(Instr_Ready), .SR1(SR1), .SR2(SR2), .ReadReg1(ReadReg1),
      .ReadReg2(ReadReg2), .WB_RegW(WB_RegW), .WB_DR(WB_DR), .WB_Data(WB_Data),
      .Op_Valid(Op_Valid), .Op_Ready(Op_Ready), .A(A), .B(B), .Imm(Imm),
      .ALUOp(ALUOp), .DR_Out(DR_Out), .RegW_Out(RegW_Out), .ALUSrc(ALUSrc),
      .MemR(MemR), .MemW(MemW), .Branch(Branch), .Illegal(Illegal)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) begin
      ReadReg1 <= rf[SR1];
      ReadReg2 <= rf[SR2];
   end
   assign ov = {A, B, Imm, ALUOp, DR_Out, RegW_Out, ALUSrc, MemR, MemW, Branch, Illegal};

   typedef struct {
      logic [31:0] ins;
      logic [4:0] sr1, sr2;
      logic [109:0] ov;
   } vec_t;
   vec_t vt [13];

   function automatic logic [109:0] mk(input logic [31:0] a, b, imm, input logic [2:0] op,
                                       input logic [4:0] dr, input logic [5:0] f);
      return {a, b, imm, op, dr, f};
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, exp);
      n++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic to_hold(input logic [31:0] ins, input logic [4:0] s1, s2,
                          input logic w0, input logic [4:0] d0, input logic [31:0] x0,
                          input logic w1, input logic [4:0] d1, input logic [31:0] x1);
      @(negedge CLK);
      Instr_In = ins; Instr_Valid = 1; WB_RegW = w0; WB_DR = d0; WB_Data = x0;
      #1 chk("idle_ready", Instr_Ready, 1);
      chk("sr_idle", {SR1, SR2}, {s1, s2});
      @(posedge CLK);
      @(negedge CLK);
      Instr_Valid = 0; Instr_In = '1; WB_RegW = w1; WB_DR = d1; WB_Data = x1;
      #1 chk("sr_read", {SR1, SR2}, {s1, s2});
      chk("read_hs", {Instr_Ready, Op_Valid}, 2'b00);
      @(posedge CLK);
      @(negedge CLK);
      WB_RegW = 0; WB_DR = 0; WB_Data = 0;
      #1 chk("hold_hs", {Instr_Ready, Op_Valid}, 2'b01);
   endtask

   task automatic finish_op;
      Op_Ready = 1;
      @(posedge CLK);
      @(negedge CLK);
      Op_Ready = 0;
      #1 chk("done_hs", {Instr_Ready, Op_Valid}, 2'b10);
   endtask

   logic [31:0] exp_a;
   logic [31:0] exp_b;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      rf[0] = 0; rf[1] = 5; rf[2] = 7;
      vt[0]  = '{32'h00221820, 5'd1, 5'd2, mk(5, 7, 32'h1820, 0, 3, 6'b100000)};
      vt[1]  = '{32'h2024FFFF, 5'd1, 5'd4, mk(5, 32'h1004, 32'hFFFFFFFF, 0, 4, 6'b110000)};
      vt[2]  = '{32'h34058000, 5'd0, 5'd5, mk(0, 32'h1005, 32'h00008000, 3, 5, 6'b110000)};
      vt[3]  = '{32'hFC000000, 5'd0, 5'd0, mk(0, 0, 0, 0, 0, 6'b000001)};
      vt[4]  = '{32'h00220020, 5'd1, 5'd2, mk(5, 7, 32'h20, 0, 0, 6'b000000)};
      vt[5]  = '{32'h00622022, 5'd3, 5'd2, mk(32'h1003, 7, 32'h2022, 1, 4, 6'b100000)};
      vt[6]  = '{32'h0022282A, 5'd1, 5'd2, mk(5, 7, 32'h282A, 4, 5, 6'b100000)};
      vt[7]  = '{32'h3026F0F0, 5'd1, 5'd6, mk(5, 32'h1006, 32'h0000F0F0, 2, 6, 6'b110000)};
      vt[8]  = '{32'h8C47FFFC, 5'd2, 5'd7, mk(7, 32'h1007, 32'hFFFFFFFC, 0, 7, 6'b111000)};
      vt[9]  = '{32'hAC230008, 5'd1, 5'd3, mk(5, 32'h1003, 32'h8, 0, 3, 6'b010100)};
      vt[10] = '{32'h10228000, 5'd1, 5'd2, mk(5, 7, 32'hFFFF8000, 1, 2, 6'b000010)};
      vt[11] = '{32'h00221821, 5'd1, 5'd2, mk(5, 7, 32'h1821, 0, 3, 6'b000001)};
      vt[12] = '{32'h8C400004, 5'd2, 5'd0, mk(7, 0, 32'h4, 0, 0, 6'b011000)};

      #12;
      chk("reset_out", {Instr_Ready, Op_Valid, ov}, {2'b10, 110'd0});
      @(negedge CLK) RST_N = 1;

      for (int i = 0; i < 13; i++) begin
         to_hold(vt[i].ins, vt[i].sr1, vt[i].sr2, 0, 0, 0, 0, 0, 0);
         chk($sformatf("vec%0d", i), ov, vt[i].ov);
         finish_op();
      end

      // backpressure: outputs frozen, new instruction offered but not taken
      to_hold(32'h00221820, 1, 2, 0, 0, 0, 0, 0, 0);
      Instr_In = 32'h34058000; Instr_Valid = 1; rf[1] = 32'hDEAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         #1 chk($sformatf("bp_ov%0d", c), ov, vt[0].ov);
         chk($sformatf("bp_hs%0d", c), {Instr_Ready, Op_Valid}, 2'b01);
      end
      Instr_Valid = 0; rf[1] = 5;
      finish_op();
      chk("bp_after", ov, vt[0].ov);

      // forwarding on accept edge, zero register, capture edge, later-wins
`ifdef MIPS_DECODE_FWD_EN
      exp_a = 32'h55;
`else
      exp_a = 5;
`endif
      to_hold(32'h00221820, 1, 2, 1, 1, 32'h55, 0, 0, 0);
      chk("fwd_accept_a", A, exp_a);
      chk("fwd_accept_b", B, 7);
      finish_op();
      to_hold(32'h34058000, 0, 5, 1, 0, 32'h99, 0, 0, 0);
      chk("fwd_zero_a", A, 0);
      finish_op();
`ifdef MIPS_DECODE_FWD_EN
      exp_b = 32'h66;
`else
      exp_b = 7;
`endif
      to_hold(32'h00221820, 1, 2, 0, 0, 0, 1, 2, 32'h66);
      chk("fwd_read_b", B, exp_b);
      finish_op();
`ifdef MIPS_DECODE_FWD_EN
      exp_a = 32'h22;
`else
      exp_a = 5;
`endif
      to_hold(32'h00221820, 1, 2, 1, 1, 32'h11, 1, 1, 32'h22);
      chk("fwd_later_a", A, exp_a);
      finish_op();

      // reset while holding an operation
      to_hold(32'h8C47FFFC, 2, 7, 0, 0, 0, 0, 0, 0);
      #2 RST_N = 0;
      #1 chk("rst_async", {Instr_Ready, Op_Valid, ov}, {2'b10, 110'd0});
      @(negedge CLK) RST_N = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         #1 chk($sformatf("rst_after%0d", c), {Instr_Ready, Op_Valid, ov}, {2'b10, 110'd0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule

// File: doc/mips_decode_stage.md
MIPS_DECODE_STAGE -- requirements
Module: mips_decode_stage

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports Instr_In (input, 32), Instr_Valid (input, 1) and Instr_Ready (output, 1): the fetched-instruction handshake.
REQ-004 SHALL have ports SR1 and SR2 (output, 5 each): register-file read addresses.
REQ-005 SHALL have ports ReadReg1 and ReadReg2 (input, 32 each): register-file read data, valid one cycle after the address is sampled.
REQ-006 SHALL have ports WB_RegW (input, 1), WB_DR (input, 5) and WB_Data (input, 32): the write-back bus to the register file.
REQ-007 SHALL have these outputs to execute:
- Op_Valid (1); Op_Ready is an input (1).
- A, B, Imm (32 each).
- ALUOp (3), DR_Out (5).
- RegW_Out, ALUSrc, MemR, MemW, Branch, Illegal (1 each).

Function
REQ-008 SHALL implement FSM IDLE -> READ -> HOLD -> IDLE.
- IDLE -> READ: on Instr_Valid=1.
- READ -> HOLD: unconditional.
- HOLD -> IDLE: on Op_Ready=1.
REQ-009 SHALL drive Instr_Ready=1 only in IDLE; an instruction is accepted on a rising edge with Instr_Valid=1 and Instr_Ready=1, and is then latched.
REQ-010 SHALL drive SR1/SR2 from the instruction word:
- SR1 = bits [25:21], SR2 = bits [20:16].
- In IDLE, taken combinationally from Instr_In.
- In other states, taken from the latched instruction.
REQ-011 SHALL capture ReadReg1/ReadReg2 into A/B on the READ->HOLD edge and assert Op_Valid in HOLD; latency is 2 cycles from the accept edge to Op_Valid.
REQ-012 SHALL hold all execute outputs stable while Op_Valid=1 and Op_Ready=0, and drop Op_Valid on the edge where Op_Ready=1.
REQ-013 SHALL decode the following opcodes/functs (ALUOp: ADD=0, SUB=1, AND=2, OR=3, SLT=4):
- R-type (op 0x00): funct 0x20/0x22/0x24/0x25/0x2A.
- I-type ALU: ADDI 0x08, ANDI 0x0C, ORI 0x0D.
- Memory: LW 0x23, SW 0x2B.
- Branch: BEQ 0x04.
REQ-014 SHALL set the destination register: DR_Out = rd for R-type, rt for I-type.
REQ-015 SHALL assert RegW_Out for R-type, ADDI, ANDI, ORI and LW, except that RegW_Out SHALL be 0 when DR_Out=0.
REQ-016 SHALL form Imm as follows:
- Zero-extended imm16 for ANDI and ORI.
- Sign-extended imm16 otherwise.
- ALUSrc=1 for ADDI, ANDI, ORI, LW and SW.
REQ-017 SHALL decode the memory and branch instructions as:
- LW: MemR=1, ALUOp=ADD.
- SW: MemW=1, ALUOp=ADD.
- BEQ: Branch=1, ALUOp=SUB.
REQ-018 SHALL treat any other opcode/funct as Illegal=1, with all of RegW_Out, MemR, MemW and Branch = 0; it still completes the handshake.

Reset
REQ-019 SHALL on RST_N=0 immediately enter IDLE and clear all outputs and latched state to 0; Instr_Ready SHALL be 1 while in IDLE.
REQ-020 SHALL abandon an in-flight or held operation on reset (Op_Valid low asynchronously) and SHALL NOT re-present it after reset releases.

Configuration
REQ-021 SHALL, with macro MIPS_DECODE_FWD_EN defined, apply write-back forwarding to each operand (A from SR1, B from SR2):
- Condition: on the accept edge or the READ->HOLD edge, WB_RegW=1, WB_DR equals the operand's source register, and that register is nonzero.
- Action: the operand takes WB_Data instead of the register-file value.
- If a matching write occurs at both edges, the later one wins.
- Writes during HOLD are not tracked.
REQ-022 SHALL, without MIPS_DECODE_FWD_EN, ignore the WB_* inputs and take A/B solely from ReadReg1/ReadReg2.

Verification
REQ-023 Basic R-type:
- Stimulus: register file $1=5, $2=7; accept 0x00221820 (ADD $3,$1,$2); Op_Ready=1.
- Response: Op_Valid 2 cycles after accept; A=5, B=7, ALUOp=0, DR_Out=3, RegW_Out=1, ALUSrc=0; Instr_Ready back to 1 the following cycle.
REQ-024 Immediate extension:
- Accept 0x2024FFFF (ADDI) -> Imm=0xFFFFFFFF, ALUSrc=1, DR_Out=4.
- Accept 0x34058000 (ORI) -> Imm=0x00008000, ALUOp=3.
REQ-025 Backpressure:
- Stimulus: hold Op_Ready=0 for 3 cycles in HOLD.
- Response: all outputs unchanged and Instr_Ready=0; completes on the first edge with Op_Ready=1.
REQ-026 Forwarding:
- Stimulus: WB_RegW=1, WB_DR=1, WB_Data=0x55 on the accept edge of 0x00221820, with the register file holding $1=5.
- Response: A=0x55 with MIPS_DECODE_FWD_EN; A=5 without it.
- Stimulus: WB_DR=0 on the same edge.
- Response: no forwarding in either build.
REQ-027 Illegal and zero destination:
- Accept 0xFC000000 -> Illegal=1, RegW_Out=0, MemR=MemW=Branch=0.
- Accept 0x00220020 (DR=0) -> RegW_Out=0.
REQ-028 Reset mid-operation:
- Stimulus: assert RST_N=0 during HOLD.
- Response: Op_Valid=0 and all outputs 0 immediately; after release, Instr_Ready=1 with no residual op.
